// File: rtl/outport_display_pkg.sv
// rtl/outport_display_pkg.sv - shared state encoding, segment table and blank patterns
package outport_display_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // All anodes off / all segments off (both active-low)
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // One-hot-low anode pattern for a digit index (an[0] is the rightmost digit)
    function automatic logic [3:0] digit_an(input logic [1:0] digit);
        logic [3:0] onehot;
        onehot = 4'b0001 << digit;
        return ~onehot;
    endfunction

endpackage

// File: rtl/outport_display_hex7seg.sv
// rtl/outport_display_hex7seg.sv - combinational hex nibble to active-low 7-segment decoder
module hex7seg
    import outport_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure table lookup; no state
    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/outport_display.sv
// rtl/outport_display.sv - four-digit multiplexed hex display of two CPU output ports
module outport_display
    import outport_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYC     = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Outport0,
    input  logic [7:0] Outport1,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    // Terminal counter values for the two timed states
    localparam logic [15:0] DRIVE_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);

    state_t      state;
    logic [1:0]  digit;
    logic [15:0] cnt;
    logic [15:0] snap;
    logic [3:0]  nibble;
    logic [6:0]  seg_dec;

    // Select the nibble of the frozen snapshot belonging to the current digit
    always_comb begin
        nibble = snap[3:0];
        case (digit)
            2'd0: nibble = snap[3:0];
            2'd1: nibble = snap[7:4];
            2'd2: nibble = snap[11:8];
            2'd3: nibble = snap[15:12];
            default: nibble = snap[3:0];
        endcase
    end

    hex7seg u_hex7seg (
        .hex (nibble),
        .seg (seg_dec)
    );

    // Frame sequencer; outputs are registered from the state being left, so they lag it by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= LOAD;
            digit      <= 2'd0;
            cnt        <= 16'd0;
            snap       <= 16'h0000;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (state == LOAD);
            // blank only masks the outputs; timing and snapshot carry on untouched
            if (state == DRIVE && !blank) begin
                an  <= digit_an(digit);
                seg <= seg_dec;
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
            end

            case (state)
                LOAD: begin
                    snap  <= {Outport1, Outport0};
                    digit <= 2'd0;
                    cnt   <= 16'd0;
                    state <= DRIVE;
                end
                DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        cnt   <= 16'd0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= 16'd0;
                        if (digit == 2'd3) begin
                            state <= LOAD;
                        end else begin
                            digit <= digit + 2'd1;
                            state <= DRIVE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= LOAD;
                    digit <= 2'd0;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_outport_display.sv
// tb/tb_outport_display.sv - randomized self-checking bench against a frame-position reference model
module tb_outport_display;

    localparam int RD    = 4;
    localparam int GC    = 1;
    localparam int SLOT  = RD + GC;
    localparam int FRAME = 4 * SLOT + 1;

    logic       clk;
    logic       reset;
    logic [7:0] Outport0;
    logic [7:0] Outport1;
    logic       blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;

    // model state: edges since reset release, snapshot, reset flag
    int          e_cnt     = 0;
    logic [15:0] msnap     = 16'h0000;
    bit          in_reset  = 1'b1;
    int          cyc       = 0;
    int          last_tick = -1;

    outport_display #(
        .REFRESH_DIV (RD),
        .GAP_CYC     (GC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Outport0   (Outport0),
        .Outport1   (Outport1),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Position of the most recently executed edge within the frame
    function automatic int last_pos();
        return (e_cnt - 1) % FRAME;
    endfunction

    // One clock: predict what this edge does from its frame position, then compare
    task automatic step();
        int e, j, d, r;
        logic [3:0] ea;
        logic [6:0] es;
        logic       et;
        logic [3:0] nib;
        @(posedge clk);
        ea = 4'b1111;
        es = 7'h7F;
        et = 1'b0;
        if (!in_reset) begin
            e = e_cnt % FRAME;
            e_cnt++;
            if (e == 0) begin
                msnap = {Outport1, Outport0};
                et    = 1'b1;
            end else begin
                j = e - 1;
                d = j / SLOT;
                r = j % SLOT;
                if (r < RD && !blank) begin
                    ea  = ~(4'b0001 << d);
                    nib = msnap[d*4 +: 4];
                    es  = exp_seg(nib);
                end
            end
        end
        #1;
        check("an", an, ea);
        check("seg", seg, es);
        check("frame_tick", frame_tick, et);
        check("one_anode", 32'($countones(~an) <= 1), 1);
        if (frame_tick === 1'b1) begin
            if (last_tick >= 0) check("tick_interval", cyc - last_tick, FRAME);
            last_tick = cyc;
        end
        cyc++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_reset  = 1'b0;
        e_cnt     = 0;
        last_tick = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, an, 4'b1111);
        check({tag, "_seg"}, seg, 7'h7F);
        check({tag, "_tick"}, frame_tick, 1'b0);
    endtask

    initial begin
        int guard;
        reset    = 1'b1;
        Outport0 = 8'h34;
        Outport1 = 8'h12;
        blank    = 1'b0;

        // power-on reset
        #2 reset = 1'b0;
        in_reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (2) step();
        release_reset();

        // first frames with 12/34, then change Outport0 during digit1
        repeat (FRAME + 3) step();
        guard = 0;
        while (!(last_pos() >= 1 + SLOT && last_pos() < 1 + SLOT + RD) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        check("find_digit1", 32'(guard < 2 * FRAME), 1);
        Outport0 = 8'hAB;
        repeat (2 * FRAME) step();

        // blank spell of 10 cycles from a random phase
        repeat ($urandom_range(0, FRAME - 1)) step();
        blank = 1'b1;
        repeat (10) step();
        blank = 1'b0;
        repeat (FRAME + 2) step();

        // reset while digit2 is being driven
        guard = 0;
        while (!(last_pos() >= 1 + 2 * SLOT && last_pos() < 1 + 2 * SLOT + RD) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        check("find_digit2", 32'(guard < 2 * FRAME), 1);
        check("digit2_before_reset", an, 4'b1011);
        reset    = 1'b0;
        in_reset = 1'b1;
        #1 check_reset_outputs("mid_rst");
        repeat (3) step();
        release_reset();
        repeat (2 * FRAME) step();

        // hex sweep: one Outport0 value per frame, random Outport1
        for (int v = 0; v < 256; v++) begin
            Outport0 = 8'(v);
            Outport1 = 8'($urandom);
            repeat (FRAME) step();
        end

        // random churn of inputs and blank
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) Outport0 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) Outport1 = 8'($urandom);
            blank = ($urandom_range(0, 7) == 0);
            step();
        end
        blank = 1'b0;
        repeat (FRAME) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
